// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add rebuild of quotient*divisor+remainder with a valid/ready handshake
module shift_add_multiplier #(
  parameter int Nx = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Nx-1:0]     quotient,
  input  logic [Nx-2:0]     divisor,
  input  logic [2*Nx-2:0]   remainder,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*Nx-1:0]   product
);
  localparam int CW = $clog2(Nx + 1);
  localparam logic [CW-1:0] LAST = CW'(Nx - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]      state;
  logic [2*Nx-1:0] acc, mcand, acc_next;
  logic [Nx-1:0]   mplier;
  logic [CW-1:0]   count;
  always_comb acc_next = acc + (mplier[0] ? mcand : '0);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc    <= {1'b0, remainder};
          mcand  <= {{(Nx+1){1'b0}}, divisor};
          mplier <= quotient;
          count  <= '0;
          state  <= CALC;
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            product <= acc_next;
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and randomized checks against an arithmetic reference
module tb_shift_add_multiplier;
  localparam int NX = 5;
  logic              clk = 0;
  logic              rst = 1;
  logic              in_valid = 0;
  logic              in_ready;
  logic [NX-1:0]     quotient = '0;
  logic [NX-2:0]     divisor = '0;
  logic [2*NX-2:0]   remainder = '0;
  logic              out_valid;
  logic              out_ready = 0;
  logic [2*NX-1:0]   product;
  int passed = 0;
  int total = 0;
  shift_add_multiplier #(.Nx(NX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  // Launch one operation and verify it takes exactly NX calc cycles to reach DONE
  task automatic op(input int d, input int q, input int r, input bit ordy);
    divisor = (NX-1)'(d);
    quotient = NX'(q);
    remainder = (2*NX-1)'(r);
    in_valid = 1;
    out_ready = ordy;
    chk("in_ready_idle", in_ready, 1);
    tick;
    in_valid = 0;
    divisor = '1;
    quotient = '1;
    remainder = '1;
    for (int i = 0; i < NX; i++) begin
      chk("busy_out_valid", out_valid, 0);
      chk("busy_in_ready", in_ready, 0);
      tick;
    end
    chk("done_out_valid", out_valid, 1);
    chk("done_product", product, 64'(q * d + r));
    if (ordy) begin
      tick;
      chk("post_in_ready", in_ready, 1);
      chk("post_out_valid", out_valid, 0);
      chk("post_product_hold", product, 64'(q * d + r));
    end
  endtask
  initial begin
    longint exp_q[$];
    int got = 0;
    int cyc = 0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_product", product, 0);
    tick;
    tick;
    rst = 0;
    op(7, 9, 5, 1);
    op(15, 31, 511, 1);
    op(0, 0, 0, 1);
    op(5, 6, 1, 0);
    in_valid = 1;
    divisor = 9;
    quotient = 10;
    remainder = 3;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_product", product, 31);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    tick;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    tick;
    in_valid = 0;
    chk("bp_accept", in_ready, 0);
    repeat (NX) tick;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_product", product, 93);
    tick;
    op(2, 3, 1, 0);
    rst = 1;
    #1;
    chk("rst_done_valid", out_valid, 0);
    rst = 0;
    op(4, 5, 6, 1);
    divisor = 6;
    quotient = 7;
    remainder = 8;
    in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    #2;
    rst = 1;
    #1;
    chk("rst_calc_out_valid", out_valid, 0);
    chk("rst_calc_product", product, 0);
    chk("rst_calc_in_ready", in_ready, 1);
    #1;
    rst = 0;
    tick;
    op(3, 4, 2, 1);
    while (got < 1000 && cyc < 60000) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      divisor = (NX-1)'($urandom);
      quotient = NX'($urandom);
      remainder = (2*NX-1)'($urandom);
      if (out_valid) chk("rand_product", product, exp_q.size() > 0 ? exp_q[0] : 64'hFFFF_FFFF_FFFF_FFFF);
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) exp_q.push_back(longint'(quotient) * longint'(divisor) + longint'(remainder));
      tick;
      cyc++;
    end
    chk("rand_done_count", got, 1000);
    chk("rand_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter Nx, default 5, quotient width; divisor width Nx-1, remainder width 2*Nx-1, result width 2*Nx; Nx SHALL be >= 2.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operand set valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 quotient  input  Nx  unsigned multiplier operand.
REQ-008 divisor  input  Nx-1  unsigned multiplicand operand.
REQ-009 remainder  input  2*Nx-1  unsigned addend.
REQ-010 out_valid  output  1  product valid.
REQ-011 out_ready  input  1  consumer accepts product.
REQ-012 product  output  2*Nx  quotient*divisor+remainder, unsigned.

Function
REQ-013 The block SHALL rebuild a dividend from divider outputs: product = quotient*divisor + remainder, exact, no truncation (max fits 2*Nx bits).
REQ-014 FSM states SHALL be IDLE, CALC, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), both registered-state decodes.
REQ-015 IDLE: on in_valid&in_ready at a rising edge, register acc=remainder (zero-extended), mcand=divisor (zero-extended to 2*Nx), mplier=quotient, count=0; go CALC.
REQ-016 CALC: each cycle, acc += mplier[0] ? mcand : 0; mcand <<= 1; mplier >>= 1; count += 1.
REQ-017 CALC SHALL last exactly Nx cycles regardless of operand values (no early exit on zero); after the Nx-th CALC edge, product=acc and state=DONE.
REQ-018 Latency: out_valid SHALL be high after the Nx-th rising edge following the accepting edge (Nx+1 cycles from sampled in_valid to out_valid).
REQ-019 DONE: product and out_valid SHALL hold stable until out_valid&out_ready at a rising edge, then go IDLE.
REQ-020 in_valid in CALC or DONE SHALL be ignored (in_ready low); no operand queueing.
REQ-021 Back-to-back: the earliest next accept SHALL be the edge after the output handshake edge (one IDLE cycle minimum).
REQ-022 product SHALL retain its last value in IDLE and CALC until overwritten at CALC->DONE.
REQ-023 Operand inputs SHALL be sampled only at the accepting edge; changes afterwards have no effect.
REQ-024 count SHALL be ceil(log2(Nx+1)) bits; acc additions SHALL not overflow 2*Nx bits.

Reset
REQ-025 rst high SHALL immediately force state=IDLE, acc, mcand, mplier, count, product = 0; hence in_ready=1 (after release), out_valid=0, product=0.
REQ-026 rst asserted mid-CALC or in DONE SHALL abort the operation with no output handshake; first accept allowed on the first edge after rst deasserts.

Verification (Nx=5)
REQ-027 divisor=7, quotient=9, remainder=5, out_ready=1 -> out_valid high after 5th edge post-accept, product=68, in_ready high one cycle later.
REQ-028 divisor=15, quotient=31, remainder=511 -> product=976; divisor=0, quotient=0, remainder=0 -> product=0, still exactly 5 CALC cycles.
REQ-029 Backpressure: out_ready low 3 cycles in DONE with in_valid high and new operands -> product stable, in_ready=0, new operands not taken; out_ready high -> handshake, IDLE, then accept.
REQ-030 rst pulsed on 2nd CALC cycle -> out_valid=0, product=0, in_ready=1 after release; next op divisor=3, quotient=4, remainder=2 -> product=14.
REQ-031 Random 1000 operand sets with random in_valid/out_ready -> each product equals quotient*divisor+remainder, in order, none dropped or duplicated.
